uart_tx_drain: RTL and testbench
================================

UART_TX_DRAIN -- requirements
Module: uart_tx_drain

Interface
REQ-001 The block SHALL have parameter STOP_BITS, default 1, number of stop bits per frame (legal values 1 or 2).
REQ-002 The block SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 The block SHALL have port fifo_empty  input  1  empty flag of the upstream FIFO.
REQ-005 The block SHALL have port fifo_data  input  8  upstream FIFO head byte, valid whenever fifo_empty=0.
REQ-006 The block SHALL have port fifo_read  output  1  pop request to the FIFO; the FIFO pops on the same clock edge.
REQ-007 The block SHALL have port baud_div  input  16  clocks per bit period.
REQ-008 The block SHALL have port parity_en  input  1  insert a parity bit when 1.
REQ-009 The block SHALL have port parity_odd  input  1  odd parity when 1, even parity when 0.
REQ-010 The block SHALL have port tx  output  1  serial line, idle high, registered.
REQ-011 The block SHALL have port busy  output  1  high while a frame is in progress, registered.
REQ-012 The block SHALL have port frame_done  output  1  one-cycle pulse at the end of each frame, registered.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; busy = (state != IDLE).
REQ-014 Bit period SHALL be max(baud_div,1) clocks; a 16-bit baud counter SHALL count 0..period-1 and advance the bit on terminal count.
REQ-015 baud_div, parity_en and parity_odd SHALL be latched when a byte is popped; changes mid-frame SHALL have no effect until the next frame.
REQ-016 fifo_read SHALL be combinational: reset_n & ~fifo_empty & (state==IDLE | last clock of the final stop bit).
REQ-017 On a cycle with fifo_read=1, fifo_data SHALL be captured into the shift register and the state SHALL go to START; tx SHALL go low on the next clock (latency 1).
REQ-018 DATA SHALL send 8 bits, LSB first, one bit per period, using a 3-bit bit index.
REQ-019 PARITY SHALL be entered only if the latched parity_en=1; its bit SHALL be XOR of the 8 data bits, inverted when the latched parity_odd=1.
REQ-020 STOP SHALL drive tx=1 for STOP_BITS periods.
REQ-021 frame_done SHALL pulse for one cycle on the first clock after the last stop bit ends, whether the next state is IDLE or START.
REQ-022 Back-to-back frames SHALL have zero idle gap: when the FIFO is non-empty at the end of the final stop bit, the pop happens in that cycle and START follows immediately.
REQ-023 With fifo_empty=1 in IDLE, fifo_read SHALL stay 0 and tx SHALL stay 1 indefinitely.
REQ-024 The block SHALL never assert fifo_read while fifo_empty=1 (no underflow).
REQ-025 Frame length SHALL be (10 + parity_en + STOP_BITS - 1) × period clocks.

Reset
REQ-026 With reset_n=0 at a clock edge, the following SHALL be set: state=IDLE, tx=1, busy=0, frame_done=0, counters and shift register cleared; fifo_read SHALL be 0 throughout reset.
REQ-027 A reset mid-frame SHALL abort the frame; the byte is lost, tx is high on the next edge, and no frame_done pulse is generated.
REQ-028 After reset release, the first pop SHALL occur on the first cycle with fifo_empty=0.

Verification
REQ-029 baud_div=4, parity_en=0, one byte 0xA5: one fifo_read pulse -> tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 clocks; frame_done 40 clocks after tx falls.
REQ-030 baud_div=4, parity_en=1, byte 0xA5: parity_odd=0 -> parity bit 0; parity_odd=1 -> parity bit 1; frame 44 clocks.
REQ-031 Two bytes 0x00, 0xFF queued, baud_div=2: fifo_read pulses exactly 20 clocks apart; no tx-high gap between stop bit and second start bit; two frame_done pulses.
REQ-032 baud_div=0, byte 0x55: period treated as 1 -> frame 10 clocks, tx toggles 0,1,0,1,0,1,0,1,0,1.
REQ-033 baud_div changed from 4 to 8 during the DATA state -> current frame stays at 4 clocks/bit; the next frame uses 8 clocks/bit.
REQ-034 reset_n=0 for 1 clock during data bit 3 with the FIFO holding 1 byte -> tx=1 and busy=0 after the edge; the held byte is popped on the first cycle after release and a full frame follows.

Source files
------------

// File: rtl/uart_tx_drain.sv
// UART transmitter that drains an upstream show-ahead FIFO, one 8N1/8P1 frame per byte.
// Line settings are captured with each byte, so they only take effect at frame boundaries.
module uart_tx_drain #(
    parameter int unsigned STOP_BITS = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_read,
    input  logic [15:0] baud_div,
    input  logic        parity_en,
    input  logic        parity_odd,
    output logic        tx,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic STOP_LAST = (STOP_BITS == 2);

    logic [2:0]  state_q,   state_d;
    logic [15:0] cnt_q,     cnt_d;
    logic [15:0] last_q,    last_d;
    logic [2:0]  bit_q,     bit_d;
    logic        stop_q,    stop_d;
    logic [7:0]  shift_q,   shift_d;
    logic        par_en_q,  par_en_d;
    logic        par_bit_q, par_bit_d;
    logic        tx_q,      tx_d;
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;

    logic tick;
    logic last_stop;

    assign tick      = (cnt_q == last_q);
    assign last_stop = (state_q == STOP) && tick && (stop_q == STOP_LAST);
    assign fifo_read = reset_n & ~fifo_empty & ((state_q == IDLE) | last_stop);

    always_comb begin
        state_d   = state_q;
        cnt_d     = tick ? '0 : cnt_q + 16'd1;
        last_d    = last_q;
        bit_d     = bit_q;
        stop_d    = stop_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: cnt_d = '0;
            START: begin
                if (tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        state_d = par_en_q ? PARITY : STOP;
                        stop_d  = 1'b0;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    stop_d  = 1'b0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A pop overrides the stop->idle transition so the next start bit follows with no gap.
        if (fifo_read) begin
            state_d   = START;
            cnt_d     = '0;
            shift_d   = fifo_data;
            last_d    = (baud_div == 16'd0) ? '0 : baud_div - 16'd1;
            par_en_d  = parity_en;
            par_bit_d = (^fifo_data) ^ parity_odd;
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= '0;
            bit_q     <= '0;
            stop_q    <= 1'b0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            bit_q     <= bit_d;
            stop_q    <= stop_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Scoreboard bench for uart_tx_drain: directed bytes push hand-computed line patterns,
// a monitor captures each frame on tx and compares it clock by clock.
module tb_uart_tx_drain;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_read;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        tx;
    logic        busy;
    logic        frame_done;

    uart_tx_drain #(.STOP_BITS(1)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_read  (fifo_read),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int underflow = 0;

    logic [7:0] fq[$];
    int         pop_cyc[$];
    string      exp_lv[$];
    int         exp_per[$];

    logic       samples[$];
    bit         in_frame = 1'b0;
    bit         prev_fd  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Line pattern: one character per bit period, start bit first.
    task automatic send(input logic [7:0] b, input string lv, input int per);
        fq.push_back(b);
        exp_lv.push_back(lv);
        exp_per.push_back(per);
    endtask

    task automatic finish_frame();
        string lv;
        int    per;
        int    n;
        int    bad_idx;
        if (exp_lv.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL unexpected_frame: got frame of %0d clocks, expected none", samples.size());
            return;
        end
        lv  = exp_lv.pop_front();
        per = exp_per.pop_front();
        n   = lv.len() * per;
        check($sformatf("frame_len[%s]", lv), samples.size(), n);
        bad_idx = -1;
        for (int i = 0; i < samples.size() && i < n; i++) begin
            if (bad_idx < 0 && samples[i] !== (lv[i / per] == 8'h31)) bad_idx = i;
        end
        check($sformatf("frame_levels[%s] first bad clock", lv), bad_idx, -1);
    endtask

    // FIFO model: pops on the same edge as the DUT, presents the new head shortly after.
    always @(posedge clock) begin
        logic [7:0] tmp;
        cyc++;
        if (fifo_read) begin
            if (fifo_empty) underflow++;
            if (fq.size() != 0) tmp = fq.pop_front();
            pop_cyc.push_back(cyc);
        end
        #2;
        fifo_empty = (fq.size() == 0);
        fifo_data  = (fq.size() == 0) ? 8'h00 : fq[0];
    end

    always @(negedge clock) begin
        if (frame_done) begin
            if (prev_fd) check("frame_done_width", 2, 1);
            if (in_frame) finish_frame();
            else check("frame_done_without_frame", 1, 0);
            in_frame = 1'b0;
        end else if (in_frame && !busy) begin
            in_frame = 1'b0;
        end
        if (!in_frame && busy && tx == 1'b0) begin
            in_frame = 1'b1;
            samples.delete();
        end
        if (in_frame) samples.push_back(tx);
        prev_fd = frame_done;
    end

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (exp_lv.size() == 0 && fq.size() == 0 && !busy) return;
        end
        check("wait_idle_timeout", 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int rel;
        int n0;
        int bad;
        reset_n    = 1'b0;
        baud_div   = 16'd0;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;

        repeat (3) @(negedge clock);
        check("reset_tx", int'(tx), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_frame_done", int'(frame_done), 0);

        // baud_div=0 acts as 1 clock/bit; byte waits in FIFO through reset
        send(8'h55, "0101010101", 1);
        repeat (2) @(negedge clock);
        check("fifo_read_in_reset", int'(fifo_read), 0);
        rel = cyc;
        reset_n = 1'b1;
        wait_idle(100);
        check("first_pop_after_release", (pop_cyc.size() > 0) ? pop_cyc[0] : -1, rel + 1);

        @(negedge clock);
        baud_div = 16'd4;
        send(8'hA5, "0101001011", 4);
        wait_idle(200);

        parity_en  = 1'b1;
        parity_odd = 1'b0;
        send(8'hA5, "01010010101", 4);
        wait_idle(200);

        // settings changed mid-frame must not affect this frame
        parity_odd = 1'b1;
        send(8'hA5, "01010010111", 4);
        repeat (8) @(negedge clock);
        parity_odd = 1'b0;
        parity_en  = 1'b0;
        wait_idle(200);

        baud_div = 16'd2;
        n0 = pop_cyc.size();
        send(8'h00, "0000000001", 2);
        send(8'hFF, "0111111111", 2);
        wait_idle(200);
        check("b2b_pop_count", pop_cyc.size() - n0, 2);
        if (pop_cyc.size() >= n0 + 2)
            check("b2b_pop_spacing", pop_cyc[n0 + 1] - pop_cyc[n0], 20);

        baud_div = 16'd4;
        send(8'h3C, "0001111001", 4);
        repeat (12) @(negedge clock);
        baud_div = 16'd8;
        send(8'hC3, "0110000111", 8);
        wait_idle(400);

        // reset during data bit 3: frame dropped, held byte sent after release
        baud_div = 16'd4;
        n0 = pop_cyc.size();
        fq.push_back(8'h0F);
        for (int i = 0; i < 20 && pop_cyc.size() == n0; i++) @(negedge clock);
        check("abort_first_pop", pop_cyc.size() - n0, 1);
        send(8'h81, "0100000011", 4);
        repeat (17) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        check("abort_tx", int'(tx), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_fifo_read_in_reset", int'(fifo_read), 0);
        rel = cyc;
        reset_n = 1'b1;
        wait_idle(200);
        check("abort_pop_count", pop_cyc.size() - n0, 2);
        check("abort_repop_cycle", (pop_cyc.size() > 0) ? pop_cyc[pop_cyc.size() - 1] : -1, rel + 1);

        bad = 0;
        repeat (50) begin
            @(negedge clock);
            if (tx !== 1'b1 || fifo_read !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("idle_hold_bad_cycles", bad, 0);
        check("underflow_pops", underflow, 0);
        check("scoreboard_leftover", exp_lv.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
